// File: rtl/plp_boot_pkg.sv
// Shared types and stream-format constants for the UART boot loader.
package plp_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERROR
    } boot_state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_word_asm.sv
// Big-endian word assembler: shifts bytes in MSB first and flags the 4th byte of each word.
module boot_word_asm
    import plp_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] cnt_reg;
    logic [23:0]      shift_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            shift_reg <= '0;
        end else if (clear) begin
            cnt_reg   <= '0;
            shift_reg <= '0;
        end else if (byte_en) begin
            shift_reg <= {shift_reg[15:0], byte_in};
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end

    // The completed word is presented in the same cycle as its last byte.
    assign word_valid = byte_en && (cnt_reg == CNT_W'(BYTES_PER_WORD - 1));
    assign word       = {shift_reg, byte_in};

endmodule

// File: rtl/uart_boot_loader.sv
// UART byte stream to program-memory loader; define BOOT_CHECKSUM_EN to require a trailing
// XOR checksum byte before a load is accepted.
module uart_boot_loader
    import plp_boot_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    localparam int LEN_W  = 8 * HDR_BYTES;
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [LEN_W:0] CAPACITY = (LEN_W + 1)'(2 ** ADDR_W);
    // Fires in the cycle before the limit so err lands exactly TIMEOUT_CYC clocks after the last byte.
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYC - 2);

    boot_state_e       state_reg, state_next;
    logic [LEN_W-9:0]  len_hi_reg;
    logic [ADDR_W-1:0] addr_reg, last_addr_reg;
    logic [IDLE_W-1:0] idle_reg;
    logic              mem_we_reg, cpu_hold_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;

    logic              in_load, start_ok, timeout, len_ok, last_word;
    logic [LEN_W-1:0]  len_word;
    logic              data_byte, word_valid;
    logic [31:0]       word;

    assign in_load   = state_reg inside {LEN_HI, LEN_LO, DATA, CSUM};
    assign start_ok  = start && !in_load;
    assign len_word  = {len_hi_reg, rx_data};
    assign len_ok    = (len_word != '0) && ({1'b0, len_word} <= CAPACITY);
    assign timeout   = in_load && !rx_valid && (idle_reg >= IDLE_LIMIT);
    assign data_byte = rx_valid && (state_reg == DATA);
    assign last_word = word_valid && (addr_reg == last_addr_reg);

    boot_word_asm u_word_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .byte_en    (data_byte),
        .byte_in    (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] csum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_reg <= '0;
        end else if (start_ok) begin
            csum_reg <= '0;
        end else if (data_byte) begin
            csum_reg <= csum_reg ^ rx_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (start_ok) begin
            state_next = LEN_HI;
        end else if (timeout) begin
            state_next = ERROR;
        end else begin
            case (state_reg)
                LEN_HI: if (rx_valid) state_next = LEN_LO;
                LEN_LO: if (rx_valid) state_next = len_ok ? DATA : ERROR;
`ifdef BOOT_CHECKSUM_EN
                DATA:   if (last_word) state_next = CSUM;
                CSUM:   if (rx_valid) state_next = (rx_data == csum_reg) ? DONE : ERROR;
`else
                DATA:   if (last_word) state_next = DONE;
`endif
                default: state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_hi_reg    <= '0;
            last_addr_reg <= '0;
            addr_reg      <= '0;
            idle_reg      <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            cpu_hold_reg  <= 1'b0;
        end else begin
            mem_we_reg <= word_valid;
            if (word_valid) begin
                mem_addr_reg  <= addr_reg;
                mem_wdata_reg <= word;
                addr_reg      <= addr_reg + 1'b1;
            end else if (start_ok) begin
                addr_reg <= '0;
            end

            if (state_reg == LEN_HI && rx_valid) begin
                len_hi_reg <= rx_data[LEN_W-9:0];
            end
            // Stored as the last address so the end-of-data test is a plain compare.
            if (state_reg == LEN_LO && rx_valid) begin
                last_addr_reg <= ADDR_W'(len_word - 1'b1);
            end

            if (rx_valid || start || !in_load) begin
                idle_reg <= '0;
            end else begin
                idle_reg <= idle_reg + 1'b1;
            end

            if (start_ok) begin
                cpu_hold_reg <= 1'b1;
            end else if (state_next == DONE && state_reg != DONE) begin
                cpu_hold_reg <= 1'b0;
            end
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = in_load;
    assign done      = (state_reg == DONE);
    assign err       = (state_reg == ERROR);
    assign cpu_hold  = cpu_hold_reg;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: table of load cases, scoreboard of expected writes,
// hand sequences for timeout, ignored bytes/start and mid-load reset.
module tb_uart_boot_loader;

    localparam int ADDR_W = 9;
    localparam int TO_CYC = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy, done, err, cpu_hold;

    always #5 clk = ~clk;

    uart_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_hold  (cpu_hold)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [15:0] len;
        int          nw;
        logic [31:0] base;
        logic [31:0] step;
        logic        exp_done;
    } vec_t;
    vec_t vecs[7];

    logic [31:0] payload[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (rst_n && mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", mem_wdata, e.data);
                $display("write addr=%0d data=%h", mem_addr, mem_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
    endtask

    task automatic drain(input string tag);
        rx_valid = 1'b0;
        tick();
        tick();
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Streams header + payload (+checksum) back-to-back and checks status the cycle after the last byte.
    task automatic run_load(input logic [15:0] len, input int nw, input logic bad_csum,
                            input logic exp_done, input string tag);
        logic [7:0] x;
        logic [7:0] bt;
        logic       valid_len;
        x = 8'h00;
        valid_len = (len != 16'd0) && (len <= 16'd512);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_on"}, 32'(busy), 32'd1);
        check({tag, "_hold_on"}, 32'(cpu_hold), 32'd1);
        send(len[15:8]);
        send(len[7:0]);
        for (int i = 0; i < nw; i++) begin
            for (int b = 0; b < 4; b++) begin
                bt = payload[i][31-8*b -: 8];
                x = x ^ bt;
                if (b == 3 && valid_len) exp_q.push_back('{ADDR_W'(i), payload[i]});
                send(bt);
            end
        end
`ifdef BOOT_CHECKSUM_EN
        if (valid_len && nw > 0) send(x ^ {7'b0, bad_csum});
`endif
        rx_valid = 1'b0;
        $display("load %s len=%0d done=%0b err=%0b busy=%0b hold=%0b", tag, len, done, err, busy, cpu_hold);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_err"}, 32'(err), 32'(!exp_done));
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
`ifndef BOOT_CHECKSUM_EN
        check({tag, "_last_we"}, 32'(mem_we), 32'(exp_done && nw > 0));
`endif
        drain(tag);
    endtask

    initial begin
        vecs[0] = '{16'd0,     0,   32'h0,        32'h0,        1'b0};
        vecs[1] = '{16'd513,   0,   32'h0,        32'h0,        1'b0};
        vecs[2] = '{16'hFFFF,  0,   32'h0,        32'h0,        1'b0};
        vecs[3] = '{16'd1,     1,   32'h11223344, 32'h0,        1'b1};
        vecs[4] = '{16'd3,     3,   32'h80000001, 32'h10203040, 1'b1};
        vecs[5] = '{16'd512,   512, 32'h00000000, 32'h01030507, 1'b1};
        vecs[6] = '{16'd2,     2,   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};

        #3;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_flags", {28'd0, busy, done, err, cpu_hold}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            payload.delete();
            for (int j = 0; j < vecs[i].nw; j++) payload.push_back(vecs[i].base + 32'(j) * vecs[i].step);
            run_load(vecs[i].len, vecs[i].nw, 1'b0, vecs[i].exp_done, $sformatf("vec%0d", i));
        end

        payload.delete();
        payload.push_back(32'hDEADBEEF);
        payload.push_back(32'h01020304);
        run_load(16'd2, 2, 1'b0, 1'b1, "basic");
        send(8'h00);
        send(8'h01);
        send(8'h55);
        rx_valid = 1'b0;
        tick();
        check("done_ignore_done", 32'(done), 32'd1);
        check("done_ignore_busy", 32'(busy), 32'd0);
        drain("done_ignore");

`ifdef BOOT_CHECKSUM_EN
        payload.delete();
        payload.push_back(32'h11223344);
        run_load(16'd1, 1, 1'b0, 1'b1, "csum_ok");
        run_load(16'd1, 1, 1'b1, 1'b0, "csum_bad");
`endif

        // Timeout: err exactly TO_CYC clocks after the last byte, no write.
        start = 1'b1;
        tick();
        start = 1'b0;
        send(8'h00);
        send(8'h01);
        send(8'hAA);
        send(8'hBB);
        rx_valid = 1'b0;
        repeat (TO_CYC - 2) tick();
        check("to_err_early", 32'(err), 32'd0);
        check("to_busy_early", 32'(busy), 32'd1);
        tick();
        $display("timeout err=%0b busy=%0b hold=%0b", err, busy, cpu_hold);
        check("to_err", 32'(err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_hold", 32'(cpu_hold), 32'd1);
        drain("to");

        // Reset after two of three words.
        payload.delete();
        payload.push_back(32'h0BADF00D);
        payload.push_back(32'h12345678);
        start = 1'b1;
        tick();
        start = 1'b0;
        send(8'h00);
        send(8'h03);
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (b == 3) exp_q.push_back('{ADDR_W'(i), payload[i]});
                send(payload[i][31-8*b -: 8]);
            end
        end
        rx_valid = 1'b0;
        tick();
        check("mid_two_writes", 32'(exp_q.size()), 32'd0);
        send(8'h9A);
        #2 rst_n = 1'b0;
        #1;
        $display("mid-load reset busy=%0b hold=%0b we=%0b", busy, cpu_hold, mem_we);
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_wdata", mem_wdata, 32'd0);
        check("mid_rst_flags", {28'd0, busy, done, err, cpu_hold}, 32'd0);
        rx_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Reload; a start pulse arriving mid-data must be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        send(8'h00);
        send(8'h01);
        send(8'hCA);
        send(8'hFE);
        start = 1'b1;
        send(8'hBA);
        start = 1'b0;
        exp_q.push_back('{ADDR_W'(0), 32'hCAFEBABE});
        send(8'hBE);
`ifdef BOOT_CHECKSUM_EN
        send(8'h30);
`else
        check("reload_we", 32'(mem_we), 32'd1);
`endif
        rx_valid = 1'b0;
        $display("reload done=%0b err=%0b hold=%0b", done, err, cpu_hold);
        check("reload_done", 32'(done), 32'd1);
        check("reload_err", 32'(err), 32'd0);
        check("reload_hold", 32'(cpu_hold), 32'd0);
        drain("reload");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Program loader that writes a 32-bit instruction image into the dual-port program memory from a byte stream delivered by the UART receiver. It parses a length header, assembles big-endian words, and issues one memory write per word at consecutive addresses from 0. It holds the CPU in reset for the whole load. This block is the write side of the boot memory that the CPU otherwise only reads.

## Interface
- `ADDR_W`, default 9 — memory word-address width; capacity is 2**ADDR_W words (512).
- `TIMEOUT_CYC`, default 50_000_000 — maximum idle clocks allowed between bytes during a load.
- `clk` input 1 — single clock; all logic is on the rising edge.
- `rst_n` input 1 — asynchronous active-low reset.
- `start` input 1 — one-cycle pulse that begins a load.
- `rx_valid` input 1 — one-cycle strobe; `rx_data` is valid in that cycle. At most one byte per cycle.
- `rx_data` input 8 — received byte.
- `mem_we` output 1 — memory write enable, one cycle per word.
- `mem_addr` output ADDR_W — word address of the write.
- `mem_wdata` output 32 — word written.
- `busy` output 1 — a load is in progress.
- `done` output 1 — the last load completed successfully (sticky).
- `err` output 1 — the last load failed (sticky).
- `cpu_hold` output 1 — holds the CPU in reset.

## Operation
- Stream format:
  - LEN_HI, LEN_LO: word count N, 16-bit big-endian.
  - Then N×4 data bytes, MSB first within each word.
  - Then a CSUM byte, only when checksum is enabled (see Configuration).
- States and transitions:
  - IDLE → LEN_HI on `start`.
  - LEN_HI → LEN_LO on a byte.
  - LEN_LO → DATA if 1 ≤ N ≤ 2**ADDR_W; otherwise → ERROR.
  - DATA → CSUM (if enabled) or DONE after the 4·N-th byte.
  - CSUM → DONE if the received byte equals the computed checksum; otherwise → ERROR.
  - DONE and ERROR are sticky. `start` re-enters LEN_HI and clears `done`/`err`.
- Word assembly: `word = {word[23:0], rx_data}`; a 2-bit byte counter tracks position. When the 4th byte of a word arrives, the word and the current address are registered.
- Write address starts at 0 and increments by 1 after each write. It never wraps, because N is bounded by capacity.
- Bytes received in IDLE, DONE or ERROR are ignored. `start` while `busy` is ignored.
- Timeout: the idle counter clears on every `rx_valid` and on `start`. Reaching TIMEOUT_CYC while `busy` → ERROR. No partial-word write happens on timeout.
- `cpu_hold` rises with `start`. It falls on entry to DONE. It stays high in ERROR until a successful load or reset.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `err`=0, `cpu_hold`=0, state IDLE, counters 0.
- `start` in cycle t → `busy`=1 and `cpu_hold`=1 in t+1.
- 4th byte of a word in cycle t → `mem_we`=1 with `mem_addr`/`mem_wdata` stable in cycle t+1, for one cycle only.
- Final data byte (no checksum) or CSUM byte in cycle t → `done` (or `err`)=1 and `busy`=0 in t+1. On success, `cpu_hold`=0 in t+1; the final `mem_we` pulse coincides with that cycle.
- Back-to-back `rx_valid` every cycle must be accepted without loss.
- Asynchronous reset mid-load aborts immediately: no further writes, all outputs return to reset values. Words already written remain in memory.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - CSUM state present.
  - Checksum = XOR of all 4·N data bytes; LEN bytes are excluded.
  - A mismatch sets `err`. All words have already been written, but `cpu_hold` stays high.
- `BOOT_CHECKSUM_EN` undefined: no CSUM state and no checksum register; DATA → DONE directly.

## Structure
- Package `plp_boot_pkg`:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR);
  - localparams for the header length (2 bytes) and bytes per word (4).
- One sub-module, `boot_word_asm`: shift register plus byte counter. Output is `word_valid`/`word`; clears on `start`.
- FSM, address counter, timeout counter and checksum live in the top level.

## Test plan
- Load without checksum: start, bytes 00 02 DE AD BE EF 01 02 03 04.
  - Expect `mem_we` at addr 0 = DEADBEEF, then addr 1 = 01020304.
  - Then `done`=1, `cpu_hold`=0, `err`=0.
- Checksum on (`BOOT_CHECKSUM_EN`): 00 01 11 22 33 44 followed by 44 (11^22^33^44=44) → `done`=1. The same stream with a final byte of 45 → `err`=1 and `cpu_hold`=1.
- Bad length:
  - 00 00 → `err`=1 after LEN_LO, no `mem_we`.
  - 02 01 (513 words) → `err`=1, no `mem_we`.
- Timeout (TIMEOUT_CYC=100): 00 01 AA BB, then silence → `err` asserted 100 clocks after byte BB; no write occurs.
- Boundary: N=512 with every byte sent back-to-back on consecutive cycles → 512 writes at addresses 0..511, no byte dropped, `done`=1.
- Reset mid-load: `rst_n`=0 after 2 of 3 words → all outputs at reset values immediately. A new start followed by 00 01 CA FE BA BE writes CAFEBABE at addr 0.
